// File: rtl/fg_mon_pkg.sv
// Shared definitions for the f/g event monitor: FSM state encoding,
// default sizing constants and a saturating-increment helper.
package fg_mon_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned WINDOW_DEF = 4;

    // Add one to v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fg_edge_det.sv
// Rising-edge detector for one upstream level signal.
// Build option: FG_GLITCH_FILTER_EN inserts a 2-sample agreement filter
// ahead of the detector (one extra cycle of latency, 1-cycle pulses dropped).
module fg_edge_det
    import fg_mon_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level_q,
    output logic rise
);

`ifdef FG_GLITCH_FILTER_EN
    logic raw_q;
    logic level_d;

    // The filtered level only follows the input once two consecutive samples agree.
    assign level_d = (d == raw_q) ? d : level_q;
    assign rise    = level_d & ~level_q;

    // Track the last raw sample and the filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            raw_q   <= d;
            level_q <= level_d;
        end
    end
`else
    assign rise = d & ~level_q;

    // Previous sample of the input; updated every edge regardless of en/clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= d;
        end
    end
`endif

endmodule

// File: rtl/fg_event_monitor.sv
// f/g activity monitor: saturating rise counters plus an IDLE/ARMED
// sequence FSM that reports "g rose within WINDOW edges of f rising"
// (match) or "window expired" (timeout). All outputs are registered.
// Build option: FG_GLITCH_FILTER_EN (see fg_edge_det).
//
//   state    | meaning
//   ST_IDLE  | waiting for an f rise
//   ST_ARMED | f rose; counting edges while waiting for a g rise
module fg_event_monitor
    import fg_mon_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned WINDOW = WINDOW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             f,
    input  logic             g,
    output logic [CNT_W-1:0] f_cnt,
    output logic [CNT_W-1:0] g_cnt,
    output logic [CNT_W-1:0] match_cnt,
    output logic             match,
    output logic             timeout,
    output logic             busy
);

    localparam int unsigned TMR_W = $clog2(WINDOW + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);

    logic             f_lvl_q, g_lvl_q;
    logic             f_rise, g_rise;
    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] f_cnt_q, f_cnt_d;
    logic [CNT_W-1:0] g_cnt_q, g_cnt_d;
    logic [CNT_W-1:0] m_cnt_q, m_cnt_d;
    logic             match_q, match_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    fg_edge_det u_f_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (f),
        .level_q (f_lvl_q),
        .rise    (f_rise)
    );

    fg_edge_det u_g_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (g),
        .level_q (g_lvl_q),
        .rise    (g_rise)
    );

    // Next-state: clr beats en, en=0 parks the FSM, otherwise count and sequence.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        f_cnt_d   = f_cnt_q;
        g_cnt_d   = g_cnt_q;
        m_cnt_d   = m_cnt_q;
        match_d   = 1'b0;
        timeout_d = 1'b0;

        if (clr) begin
            state_d = ST_IDLE;
            timer_d = '0;
            f_cnt_d = '0;
            g_cnt_d = '0;
            m_cnt_d = '0;
        end else if (!en) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            if (f_rise) f_cnt_d = CNT_W'(sat_inc(32'(f_cnt_q), CNT_W));
            if (g_rise) g_cnt_d = CNT_W'(sat_inc(32'(g_cnt_q), CNT_W));

            unique case (state_q)
                ST_IDLE: begin
                    if (f_rise && g_rise) begin
                        match_d = 1'b1;
                        m_cnt_d = CNT_W'(sat_inc(32'(m_cnt_q), CNT_W));
                    end else if (f_rise) begin
                        state_d = ST_ARMED;
                        timer_d = '0;
                    end
                end
                ST_ARMED: begin
                    if (g_rise) begin
                        match_d = 1'b1;
                        m_cnt_d = CNT_W'(sat_inc(32'(m_cnt_q), CNT_W));
                        timer_d = '0;
                        state_d = f_rise ? ST_ARMED : ST_IDLE;
                    end else if (f_rise) begin
                        timer_d = '0;
                    end else if (timer_q == TMR_LAST) begin
                        timeout_d = 1'b1;
                        timer_d   = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end

        busy_d = (state_d == ST_ARMED);
    end

    // Register FSM, timer, counters and the output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            f_cnt_q   <= '0;
            g_cnt_q   <= '0;
            m_cnt_q   <= '0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            f_cnt_q   <= f_cnt_d;
            g_cnt_q   <= g_cnt_d;
            m_cnt_q   <= m_cnt_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign f_cnt     = f_cnt_q;
    assign g_cnt     = g_cnt_q;
    assign match_cnt = m_cnt_q;
    assign match     = match_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule
